// File: rtl/ov7670_capture.sv
// OV7670 capture: syncs the camera bus into clk, pairs bytes into RGB565 and
// emits a linear framebuffer write stream.
// Ports: clk, rst_n, enable, cam_* in; wr_en/wr_addr/wr_data, frame_done, frame_err, busy out.
// Optional: OV7670_CAPTURE_DECIMATE_EN writes only even columns of even lines.
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int AWIDTH   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [9:0]        cam_data,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] HMAX = CW'(H_ACTIVE);
  localparam logic [LW-1:0] VMAX = LW'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE, SYNC, FRAME, DONE
  } st_t;

  st_t state;

  logic       pclk_s1, pclk_s2, pclk_s3;
  logic       href_s1, href_s2, href_s3;
  logic       vs_s1, vs_s2, vs_s3;
  logic [7:0] dat_s1, dat_s2;

  logic              seen_hi;
  logic              tog;
  logic              has_pix;
  logic [7:0]        hi;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line;
  logic [AWIDTH-1:0] addr;

  logic unused_bits;
  assign unused_bits = ^cam_data[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s1 <= 1'b0;
      pclk_s2 <= 1'b0;
      pclk_s3 <= 1'b0;
      href_s1 <= 1'b0;
      href_s2 <= 1'b0;
      href_s3 <= 1'b0;
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_s3   <= 1'b0;
      dat_s1  <= '0;
      dat_s2  <= '0;
    end else begin
      pclk_s1 <= cam_pclk;
      pclk_s2 <= pclk_s1;
      pclk_s3 <= pclk_s2;
      href_s1 <= cam_href;
      href_s2 <= href_s1;
      href_s3 <= href_s2;
      vs_s1   <= cam_vsync;
      vs_s2   <= vs_s1;
      vs_s3   <= vs_s2;
      dat_s1  <= cam_data[9:2];
      dat_s2  <= dat_s1;
    end
  end

  logic pclk_rise, href_fall, vs_rise;
  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign href_fall = href_s3 & ~href_s2;
  assign vs_rise   = vs_s2 & ~vs_s3;

  logic in_win, keep;
  assign in_win = (col < HMAX) && (line < VMAX);
`ifdef OV7670_CAPTURE_DECIMATE_EN
  assign keep = ~col[0] & ~line[0];
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      seen_hi    <= 1'b0;
      tog        <= 1'b0;
      has_pix    <= 1'b0;
      hi         <= '0;
      col        <= '0;
      line       <= '0;
      addr       <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (enable) begin
            state   <= SYNC;
            busy    <= 1'b1;
            seen_hi <= 1'b0;
          end
        end
        SYNC: begin
          // Only a full high-then-low VSYNC arms a frame.
          if (vs_s2) begin
            seen_hi <= 1'b1;
          end else if (seen_hi) begin
            state     <= FRAME;
            frame_err <= 1'b0;
            tog       <= 1'b0;
            has_pix   <= 1'b0;
            col       <= '0;
            line      <= '0;
            addr      <= '0;
          end
        end
        FRAME: begin
          if (vs_rise) begin
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            if (line < VMAX) frame_err <= 1'b1;
          end else if (href_fall) begin
            col     <= '0;
            tog     <= 1'b0;
            has_pix <= 1'b0;
            if (tog) frame_err <= 1'b1;
            if (has_pix && line != VMAX) line <= line + LW'(1);
          end else if (pclk_rise && href_s2) begin
            if (!tog) begin
              hi  <= dat_s2;
              tog <= 1'b1;
            end else begin
              tog     <= 1'b0;
              has_pix <= 1'b1;
              if (col != HMAX) col <= col + CW'(1);
              if (!in_win) begin
                frame_err <= 1'b1;
              end else if (keep) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= {hi, dat_s2};
                addr    <= addr + AWIDTH'(1);
              end
            end
          end
        end
        DONE: begin
          if (enable) begin
            state   <= SYNC;
            busy    <= 1'b1;
            seen_hi <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture: a camera driver pushes expected
// writes into a queue; a per-cycle monitor pops and compares them.
module tb_ov7670_capture;

  localparam int H = 4;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int V = 4;
`else
  localparam int V = 2;
`endif
  localparam int AW = 8;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          enable = 1;
  logic          cam_pclk = 0;
  logic          cam_href = 0;
  logic          cam_vsync = 0;
  logic [9:0]    cam_data = 0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cam_pclk(cam_pclk), .cam_href(cam_href),
    .cam_vsync(cam_vsync), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  wr_t  q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic last_err = 0;
  logic [7:0] byte_val = 8'h01;
  int   m_addr, m_line;
  bit   m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    wr_t e;
    @(negedge clk);
    if (rst_n) begin
      if (frame_done) begin
        done_cnt++;
        last_err = frame_err;
        if (wr_en) chk("wr_with_done", 1, 0);
      end
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("spurious_wr", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
    end
  endtask

  task automatic pc();
    cam_pclk = 1;
    repeat (4) cyc();
    cam_pclk = 0;
    repeat (4) cyc();
  endtask

  task automatic send_line(input int nb, input bit cap);
    logic [7:0] h;
    int p;
    bit ok;
    h = 0;
    cam_href = 1;
    for (int i = 0; i < nb; i++) begin
      cam_data = {byte_val, 2'b00};
      if (cap) begin
        if (i % 2 == 0) begin
          h = byte_val;
        end else begin
          p = i / 2;
          if (p < H && m_line < V) begin
`ifdef OV7670_CAPTURE_DECIMATE_EN
            ok = (p % 2 == 0) && (m_line % 2 == 0);
`else
            ok = 1;
`endif
            if (ok) begin
              q.push_back({AW'(m_addr), h, byte_val});
              m_addr++;
            end
          end else begin
            m_err = 1;
          end
        end
      end
      pc();
      byte_val = byte_val + 8'h01;
    end
    cam_href = 0;
    if (cap) begin
      if (nb % 2 == 1) m_err = 1;
      if (nb >= 2) m_line++;
    end
    pc();
    pc();
  endtask

  task automatic vs_pulse();
    cam_vsync = 1;
    repeat (3) pc();
    cam_vsync = 0;
    repeat (2) pc();
  endtask

  task automatic run_frame(input string tag, input int nl,
                           input int n0, input int n1, input int n2,
                           input int n3, input int n4, input bit dis);
    int nb[5];
    int d0;
    nb = '{n0, n1, n2, n3, n4};
    m_addr = 0;
    m_line = 0;
    m_err  = 0;
    d0 = done_cnt;
    chk({tag, "_err_clr"}, 32'(frame_err), 0);
    for (int l = 0; l < nl; l++) begin
      send_line(nb[l], 1);
      if (dis && l == 0) enable = 0;
    end
    if (m_line < V) m_err = 1;
    cam_vsync = 1;
    repeat (3) pc();
    chk({tag, "_done"}, 32'(done_cnt - d0), 1);
    chk({tag, "_err"}, 32'(last_err), 32'(m_err));
    chk({tag, "_busy"}, 32'(busy), dis ? 0 : 1);
    chk({tag, "_qempty"}, 32'(q.size()), 0);
    cam_vsync = 0;
    repeat (2) pc();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    repeat (5) cyc();
    chk_reset("rst");
    rst_n = 1;
    repeat (5) cyc();
    vs_pulse();

    byte_val = 8'h01;
    run_frame("clean", V, 8, 8, 8, 8, 8, 0);

    m_addr = 0;
    m_line = 0;
    send_line(8, 1);
    chk("pre_rst_q", 32'(q.size()), 0);
    rst_n = 0;
    repeat (3) cyc();
    chk_reset("midrst");
    rst_n = 1;
    send_line(8, 0);
    send_line(8, 0);
    vs_pulse();
    run_frame("after_rst", V, 8, 8, 8, 8, 8, 0);

    run_frame("odd", V, 7, 8, 8, 8, 8, 0);
    run_frame("clean2", V, 8, 8, 8, 8, 8, 0);
    run_frame("wide", V, 12, 8, 8, 8, 8, 0);
    run_frame("short", 1, 8, 8, 8, 8, 8, 0);
    run_frame("tall", V + 1, 8, 8, 8, 8, 8, 0);
    run_frame("dis", V, 8, 8, 8, 8, 8, 1);

    send_line(8, 0);
    repeat (10) cyc();
    chk("idle_busy", 32'(busy), 0);
    chk("final_q", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
